// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Sequencer for the VGA stopwatch datapath. Decodes PS/2 scan-code bytes into
// start/stop, lap and clear commands, runs the stopwatch state machine and
// drives the BCD counter's tick enable, clear strobe and display freeze.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   key_code  in   [7:0] scan-code byte from the PS/2 receiver
//   key_valid in   one-cycle strobe qualifying key_code
//   tick_out  out  one-cycle count-enable pulse to the counter
//   cnt_clr   out  one-cycle clear pulse to the counter
//   lap_hold  out  high while the display shows the frozen lap value
//   state     out  [1:0] 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//   overflow  out  auto-stop reached, sticky until clear
//
// Optional feature macro: SWCTRL_AUTOSTOP_EN
//   Defined   : a 14-bit tick counter forces PAUSE and raises overflow once
//               MAX_TICKS ticks have been issued; only clear or reset recovers.
//   Undefined : overflow is tied low and the stopwatch runs indefinitely.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int          CLK_DIV   = 250000,
  parameter logic [7:0]  KEY_RUN   = 8'h29,
  parameter logic [7:0]  KEY_LAP   = 8'h2B,
  parameter logic [7:0]  KEY_CLR   = 8'h24,
  parameter int          MAX_TICKS = 9999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       tick_out,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [1:0] state,
  output logic       overflow
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  // Reject configurations the prescaler or the 14-bit tick counter cannot hold.
  if (CLK_DIV < 2 || MAX_TICKS < 1 || MAX_TICKS > 16383) begin : g_bad_params
    $error("stopwatch_ctrl: CLK_DIV must be >= 2 and MAX_TICKS in 1..16383");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t        cur;
  logic          brk;
  logic          ext;
  logic [PW-1:0] presc;

  logic is_prefix;
  logic release_ok;
  logic cmd_run;
  logic cmd_lap;
  logic cmd_clr;
  logic running;
  logic wrap;

`ifdef SWCTRL_AUTOSTOP_EN
  localparam logic [13:0] TICKS_LAST = 14'(MAX_TICKS - 1);
  logic [13:0] tick_cnt;
  logic        ovf_q;
  logic        hit;
`endif

  // A command is the release of a non-extended key: the byte must follow an
  // F0 prefix with no E0 prefix since the previous plain byte.
  always_comb begin
    is_prefix  = (key_code == 8'hF0) || (key_code == 8'hE0);
    release_ok = key_valid && !is_prefix && brk && !ext;
    cmd_lap    = release_ok && (key_code == KEY_LAP);
    cmd_clr    = release_ok && (key_code == KEY_CLR);
`ifdef SWCTRL_AUTOSTOP_EN
    cmd_run    = release_ok && (key_code == KEY_RUN) && !ovf_q;
`else
    cmd_run    = release_ok && (key_code == KEY_RUN);
`endif
    running    = (cur == RUN) || (cur == LAP);
    wrap       = running && (presc == PRESC_LAST);
`ifdef SWCTRL_AUTOSTOP_EN
    hit        = wrap && (tick_cnt == TICKS_LAST);
`endif
  end

  // Parser flags, prescaler, FSM and all registered outputs. Later
  // assignments override earlier ones, so clear has the final say.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      brk      <= 1'b0;
      ext      <= 1'b0;
      presc    <= '0;
      tick_out <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_hold <= 1'b0;
`ifdef SWCTRL_AUTOSTOP_EN
      tick_cnt <= '0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      cnt_clr  <= 1'b0;
      tick_out <= wrap;

      if (key_valid) begin
        if (key_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (key_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      // The prescaler only moves while counting; PAUSE keeps its phase.
      if (running) begin
        presc <= wrap ? '0 : presc + 1'b1;
      end

      case (cur)
        IDLE: begin
          if (cmd_run) begin
            cur      <= RUN;
            lap_hold <= 1'b0;
          end
        end
        RUN: begin
          if (cmd_run) begin
            cur      <= PAUSE;
            lap_hold <= 1'b0;
          end else if (cmd_lap) begin
            cur      <= LAP;
            lap_hold <= 1'b1;
          end
        end
        LAP: begin
          if (cmd_run) begin
            cur      <= PAUSE;
            lap_hold <= 1'b0;
          end else if (cmd_lap) begin
            cur      <= RUN;
            lap_hold <= 1'b0;
          end
        end
        PAUSE: begin
          if (cmd_run) begin
            cur      <= RUN;
            lap_hold <= 1'b0;
          end
        end
        default: begin
          cur      <= IDLE;
          lap_hold <= 1'b0;
        end
      endcase

`ifdef SWCTRL_AUTOSTOP_EN
      // The tick that reaches the limit is still emitted; the stop lands on
      // the same edge so the display never shows a value past the limit.
      if (wrap) begin
        tick_cnt <= tick_cnt + 14'd1;
      end
      if (hit) begin
        cur      <= PAUSE;
        lap_hold <= 1'b0;
        ovf_q    <= 1'b1;
      end
`endif

      // Clear beats a coincident wrap: the tick is dropped and phase restarts.
      if (cmd_clr) begin
        cur      <= IDLE;
        lap_hold <= 1'b0;
        presc    <= '0;
        tick_out <= 1'b0;
        cnt_clr  <= 1'b1;
`ifdef SWCTRL_AUTOSTOP_EN
        tick_cnt <= '0;
        ovf_q    <= 1'b0;
`endif
      end
    end
  end

  assign state = cur;

`ifdef SWCTRL_AUTOSTOP_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl (CLK_DIV=4, MAX_TICKS=5). A
// behavioural model tracks the keyboard prefix history as a byte queue, the
// running time as a cycle count modulo CLK_DIV, and the number of ticks
// issued. Directed scenarios are followed by randomized key traffic.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int MAX_TICKS = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk;
  logic       reset;
  logic [7:0] key_code;
  logic       key_valid;
  logic       tick_out;
  logic       cnt_clr;
  logic       lap_hold;
  logic [1:0] state;
  logic       overflow;

  int checks;
  int failures;

  // Reference model state
  logic [7:0] prefix_q[$];
  int         m_state;
  int         m_run_cycles;
  int         m_ticks;
  bit         m_ovf;
  bit         exp_tick;
  bit         exp_clr;

  stopwatch_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .KEY_RUN  (8'h29),
    .KEY_LAP  (8'h2B),
    .KEY_CLR  (8'h24),
    .MAX_TICKS(MAX_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .key_valid(key_valid),
    .tick_out (tick_out),
    .cnt_clr  (cnt_clr),
    .lap_hold (lap_hold),
    .state    (state),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Model reset: nothing pending, clock phase and tick tally zeroed.
  task automatic modelReset();
    prefix_q.delete();
    m_state      = M_IDLE;
    m_run_cycles = 0;
    m_ticks      = 0;
    m_ovf        = 1'b0;
    exp_tick     = 1'b0;
    exp_clr      = 1'b0;
  endtask

  // Advance the model over one clock cycle with the given key input.
  task automatic modelStep(input bit v, input logic [7:0] code);
    bit is_run, is_lap, is_clr, has_f0, has_e0, running, tick_now;
    is_run = 0; is_lap = 0; is_clr = 0;
    if (v) begin
      if (code == 8'hF0 || code == 8'hE0) begin
        prefix_q.push_back(code);
      end else begin
        has_f0 = 0; has_e0 = 0;
        foreach (prefix_q[i]) begin
          if (prefix_q[i] == 8'hF0) has_f0 = 1;
          if (prefix_q[i] == 8'hE0) has_e0 = 1;
        end
        if (has_f0 && !has_e0) begin
          is_run = (code == 8'h29);
          is_lap = (code == 8'h2B);
          is_clr = (code == 8'h24);
        end
        prefix_q.delete();
      end
    end

    running  = (m_state == M_RUN) || (m_state == M_LAP);
    tick_now = 0;
    if (running) begin
      m_run_cycles++;
      tick_now = (m_run_cycles % CLK_DIV) == 0;
    end

    exp_tick = 0;
    exp_clr  = 0;
    if (is_clr) begin
      m_state      = M_IDLE;
      m_run_cycles = 0;
      m_ticks      = 0;
      m_ovf        = 0;
      exp_clr      = 1;
    end else begin
      exp_tick = tick_now;
      if (is_run && m_ovf) is_run = 0;
      case (m_state)
        M_IDLE:  if (is_run) m_state = M_RUN;
        M_RUN:   if (is_run) m_state = M_PAUSE; else if (is_lap) m_state = M_LAP;
        M_LAP:   if (is_run) m_state = M_PAUSE; else if (is_lap) m_state = M_RUN;
        default: if (is_run) m_state = M_RUN;
      endcase
`ifdef SWCTRL_AUTOSTOP_EN
      if (tick_now) begin
        m_ticks++;
        if (m_ticks == MAX_TICKS) begin
          m_state = M_PAUSE;
          m_ovf   = 1;
        end
      end
`endif
    end
  endtask

  // Drive one cycle of input, step the model, then compare after the edge.
  task automatic applyStimulus(input bit v, input logic [7:0] code);
    logic [5:0] exp_vec;
    @(negedge clk);
    key_valid = v;
    key_code  = code;
    modelStep(v, code);
    @(posedge clk);
    #1;
    exp_vec = {2'(m_state), (m_state == M_LAP), exp_tick, exp_clr, m_ovf};
    checkOutput("cycle_outputs", {26'd0, state, lap_hold, tick_out, cnt_clr, overflow},
                {26'd0, exp_vec});
  endtask

  task automatic sendRelease(input logic [7:0] code);
    applyStimulus(1'b1, 8'hF0);
    applyStimulus(1'b1, code);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic doReset();
    @(negedge clk);
    key_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int r;
    logic [7:0] b;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    modelReset();

    // Reset state
    #3;
    checkOutput("reset_outputs", {27'd0, state, lap_hold, tick_out, cnt_clr},
                32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1. make code alone does nothing; release starts the run
    applyStimulus(1'b1, 8'h29);
    checkOutput("make_ignored", {30'd0, state}, 32'd0);
    sendRelease(8'h29);
    checkOutput("start_run", {30'd0, state}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("tick_period", {31'd0, tick_out}, {31'd0, ((i % 4) == 3)});
    end

    // 2. lap freeze and release, then pause
    sendRelease(8'h2B);
    checkOutput("lap_state", {29'd0, state, lap_hold}, {29'd0, 2'b11, 1'b1});
    idleCycles(5);
    sendRelease(8'h2B);
    checkOutput("lap_exit", {29'd0, state, lap_hold}, {29'd0, 2'b01, 1'b0});
    sendRelease(8'h29);
    checkOutput("pause_state", {30'd0, state}, 32'd2);
    idleCycles(6);

    // 3. pause with prescaler at 2, resume keeps the phase
    sendRelease(8'h24);
    sendRelease(8'h29);                 // RUN, prescaler 0
    applyStimulus(1'b1, 8'hF0);         // prescaler -> 1
    applyStimulus(1'b1, 8'h29);         // prescaler -> 2, PAUSE
    checkOutput("pause_at_2", {30'd0, state}, 32'd2);
    idleCycles(3);
    sendRelease(8'h29);
    checkOutput("resume_run", {30'd0, state}, 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("resume_no_tick", {31'd0, tick_out}, 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("resume_tick", {31'd0, tick_out}, 32'd1);

    // 4. clear coinciding with a wrap
    sendRelease(8'h24);
    sendRelease(8'h29);                 // RUN, prescaler 0
    applyStimulus(1'b1, 8'hF0);
    idleCycles(2);
    applyStimulus(1'b1, 8'h24);         // 4th running edge: wrap
    checkOutput("clr_wins", {28'd0, state, tick_out, cnt_clr}, {28'd0, 2'b00, 1'b0, 1'b1});
    applyStimulus(1'b0, 8'h00);
    checkOutput("clr_one_cycle", {31'd0, cnt_clr}, 32'd0);
    sendRelease(8'h29);
    idleCycles(4);                      // model confirms tick after full period

    // 5. extended release and unrelated keys are ignored; async reset
    applyStimulus(1'b1, 8'hE0);
    sendRelease(8'h29);
    checkOutput("ext_ignored", {30'd0, state}, 32'd1);
    sendRelease(8'h1C);
    checkOutput("other_ignored", {30'd0, state}, 32'd1);
    applyStimulus(1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {26'd0, state, lap_hold, tick_out, cnt_clr, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

`ifdef SWCTRL_AUTOSTOP_EN
    // 6. auto-stop after MAX_TICKS ticks
    sendRelease(8'h29);
    idleCycles(CLK_DIV * MAX_TICKS);
    checkOutput("autostop", {30'd0, state, overflow}, {30'd0, 2'b10, 1'b1});
    sendRelease(8'h29);
    checkOutput("ovf_run_ignored", {30'd0, state, overflow}, {30'd0, 2'b10, 1'b1});
    sendRelease(8'h24);
    checkOutput("ovf_cleared", {29'd0, state, overflow, cnt_clr}, {29'd0, 2'b00, 1'b0, 1'b1});
`endif

    // Randomized key traffic against the model
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        applyStimulus(1'b0, 8'(($urandom)));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 35)      b = 8'hF0;
        else if (r < 55) b = 8'h29;
        else if (r < 72) b = 8'h2B;
        else if (r < 77) b = 8'h24;
        else if (r < 83) b = 8'hE0;
        else if (r < 90) b = 8'h1C;
        else             b = 8'($urandom);
        applyStimulus(1'b1, b);
      end
      if (n == 1000) doReset();
    end

    @(negedge clk);
    key_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencer for the VGA stopwatch datapath. Parses PS/2 scan-code bytes into start/stop, lap and clear commands, runs the stopwatch state machine, and drives the counter's tick enable, clear strobe and display-freeze signal. Sits between the PS/2 receiver and the BCD counter / seg7dis display chain. Replaces the raw scan-code compares at the top level.

Parameters:
CLK_DIV, 250000, clk cycles per counter tick (25 MHz -> 100 Hz, 0.01 s resolution); legal range >= 2
KEY_RUN, 8'h29, scan code of the start/stop key (Space)
KEY_LAP, 8'h2B, scan code of the lap/freeze key (F)
KEY_CLR, 8'h24, scan code of the clear key (E)
MAX_TICKS, 9999, ticks before auto-stop (only used with SWCTRL_AUTOSTOP_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_code  in  8  scan-code byte from the PS/2 receiver
key_valid  in  1  one-cycle strobe; key_code is valid while it is high
tick_out  out  1  one-cycle count-enable pulse to the counter
cnt_clr  out  1  one-cycle clear pulse to the counter
lap_hold  out  1  high = display shows the frozen lap value
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
overflow  out  1  auto-stop reached (sticky until clear)

Behaviour:
- Reset values: tick_out=0, cnt_clr=0, lap_hold=0, state=IDLE, overflow=0, prescaler=0, parser flags clear.
- All outputs are registered.

Parser:
- Acts only on key_valid cycles.
- 8'hF0 sets brk. 8'hE0 sets ext.
- Any other byte:
  - brk=1, ext=0: the byte is a release code; a match with KEY_RUN, KEY_LAP or KEY_CLR produces the command.
  - Otherwise the byte is ignored (make codes, typematic repeats, extended keys).
  - brk and ext clear in both cases.
- Only a release issues a command.

FSM:
- Transitions occur on the clock edge ending the cycle with key_valid high and the code byte present. The new state is visible the next cycle (latency 1).
- IDLE:
  - RUN -> RUN
  - CLR -> IDLE with cnt_clr pulse
  - LAP ignored
- RUN:
  - RUN -> PAUSE
  - LAP -> LAP
  - CLR -> IDLE with cnt_clr pulse
- LAP:
  - LAP -> RUN
  - RUN -> PAUSE
  - CLR -> IDLE with cnt_clr pulse
- PAUSE:
  - RUN -> RUN
  - CLR -> IDLE with cnt_clr pulse
  - LAP ignored
- lap_hold=1 exactly while state=LAP. The counter keeps running underneath.

Prescaler:
- 0..CLK_DIV-1. Advances only in RUN or LAP.
- Holds its value in PAUSE, so resume keeps the phase.
- Zeroed on entry to IDLE.
- tick_out pulses for 1 cycle, the cycle after the prescaler wraps from CLK_DIV-1 to 0.
- Exact period is CLK_DIV cycles while running.

Simultaneous events:
- CLR in the same cycle as a wrap: clear wins; no tick_out, prescaler=0, cnt_clr=1.
- RUN->PAUSE in the same cycle as a wrap: the tick is still emitted, since the wrap belongs to the last running cycle.
- Reset mid-operation: immediate return to the reset values; no cnt_clr is emitted. The counter has its own reset.

Optional Feature:
SWCTRL_AUTOSTOP_EN:
- Defined:
  - An internal 14-bit tick counter increments with every tick_out and is zeroed by cnt_clr.
  - When it reaches MAX_TICKS: state forces to PAUSE (from RUN or LAP, lap_hold drops) and overflow=1.
  - While overflow=1, RUN is ignored. Only CLR (-> IDLE, overflow=0) or reset recovers.
  - Keeps the 4-digit display from wrapping.
- Undefined: overflow is tied 0, no tick counter exists, and the stopwatch runs indefinitely.

Test Plan:
(bench uses CLK_DIV=4, MAX_TICKS=5)
1. Bytes 29 (make), then F0, 29 -> state 00->01 one cycle after the 29 following F0. The make byte alone causes no change. tick_out is then high every 4th cycle.
2. In RUN, send F0 2B -> state=11, lap_hold=1, ticks continue. Send F0 2B -> state=01, lap_hold=0. Send F0 29 -> state=10, no further ticks.
3. PAUSE with prescaler=2, send F0 29 -> RUN; first tick_out exactly 2 cycles later (phase preserved).
4. Time F0 24 to coincide with the prescaler wrap in RUN -> cnt_clr=1 for 1 cycle, tick_out stays 0, state=00, prescaler=0.
5. Send E0 F0 29 and F0 1C -> no state change. Assert reset mid-RUN -> all outputs 0, state=00 asynchronously.
6. (AUTOSTOP_EN) Run to 5 ticks -> state=10, overflow=1. F0 29 ignored. F0 24 -> state=00, overflow=0, cnt_clr pulse.
